riscv_alu_arbiter: RTL and testbench
====================================

# riscv_alu_arbiter

Round-robin arbiter that shares one single-cycle basic ALU (`riscv_alu_basic`) between `NUM_REQ` requesters, such as the core EX stage and an auxiliary accelerator port. Each requester has a valid/ready request channel and a one-deep registered response slot. The block drives the ALU inputs combinationally from the granted request, then captures `result_o` and `comparison_result_o` into the winner's slot on the next clock edge. It also keeps a saturating contention counter for performance monitoring.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, range 2..8.
- `CNT_WIDTH`, default 16: width of the contention counter.

Ports:
- `clk` in 1: single clock; everything is sampled on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid_i` in `NUM_REQ`: request present, one bit per requester.
- `req_ready_o` out `NUM_REQ`: request accepted this cycle; this is the one-hot grant.
- `req_operator_i` in `NUM_REQ`×`ALU_OP_WIDTH`: operator per requester.
- `req_operand_a_i` in `NUM_REQ`×32: operand a per requester.
- `req_operand_b_i` in `NUM_REQ`×32: operand b per requester.
- `req_vector_mode_i` in `NUM_REQ`×2: vector mode per requester.
- `rsp_valid_o` out `NUM_REQ`: response slot full.
- `rsp_ready_i` in `NUM_REQ`: requester consumes its slot.
- `rsp_result_o` out `NUM_REQ`×32: registered ALU result.
- `rsp_cmp_o` out `NUM_REQ`: registered comparison result.
- `alu_operator_o` out `ALU_OP_WIDTH`: to ALU `operator_i`.
- `alu_operand_a_o` out 32: to ALU `operand_a_i`.
- `alu_operand_b_o` out 32: to ALU `operand_b_i`.
- `alu_vector_mode_o` out 2: to ALU `vector_mode_i`.
- `alu_ex_ready_o` out 1: to ALU `ex_ready_i`.
- `alu_result_i` in 32: from ALU `result_o`.
- `alu_cmp_i` in 1: from ALU `comparison_result_o`.
- `alu_ready_i` in 1: from ALU `ready_o`.
- `cnt_clear_i` in 1: clears the contention counter.
- `contention_cnt_o` out `CNT_WIDTH`: contention counter value.

## Operation
- **Eligibility.** Requester i is eligible when `req_valid_i[i]`, `alu_ready_i`, and (`!rsp_valid_o[i]` or `rsp_ready_i[i]`) all hold.
- **Arbitration.** Round-robin pointer `rr_ptr` (`$clog2(NUM_REQ)` bits).
  - The search starts at `rr_ptr` and wraps modulo `NUM_REQ`.
  - The first eligible requester is granted.
  - At most one grant per cycle.
- **Pointer update.** On a grant to k, `rr_ptr` becomes (k+1) mod `NUM_REQ`. With no grant, `rr_ptr` holds.
- **Ready path.** `req_ready_o` depends combinationally on `req_valid_i`; `req_valid_i` must not depend on `req_ready_o`.
- **Requester obligation.** While `req_valid_i[i]` is high and `req_ready_o[i]` is low, payload and valid must stay stable. The bench asserts this.
- **ALU drive while granted.** ALU outputs mux the winner's payload.
- **ALU drive while idle.** `alu_operator_o` = `ALU_ADD`, and operands and vector mode are zero, to limit toggling.
- **`alu_ex_ready_o`.** Constant 1.
- **Slot update on grant to k.** `rsp_result_o[k]` ← `alu_result_i`, `rsp_cmp_o[k]` ← `alu_cmp_i`, `rsp_valid_o[k]` ← 1.
- **Slot update otherwise.** `rsp_ready_i[k]` with `rsp_valid_o[k]` clears `rsp_valid_o[k]`; the data holds.
- **Simultaneous pop and grant, same requester.** The slot is overwritten and `rsp_valid_o` stays 1, giving full throughput.
- **`rsp_ready_i` with an empty slot.** Ignored.
- **Contention counter.** Increments by 1 in every cycle where some `req_valid_i` bit is high and its `req_ready_o` bit is low.
  - Saturates at all-ones.
  - `cnt_clear_i` has priority over increment; a clear loads 0.
- **ALU operation coverage.** Operators unsupported by the basic ALU are passed through unchanged. Their results are undefined and no checking is done here.

## Timing
- **Reset values.**
  - `rr_ptr` = 0.
  - `rsp_valid_o` = 0.
  - `rsp_result_o` = 0.
  - `rsp_cmp_o` = 0.
  - `contention_cnt_o` = 0.
  - `req_ready_o` is 0 while `rst` is high.
- **Latency.** A request accepted in cycle N has `rsp_valid_o` high in cycle N+1.
- **Throughput.** One operation per cycle aggregate. A single requester that pops every cycle also sustains one per cycle.
- **Reset mid-operation.** A held request is dropped, and pending response slots are discarded in the reset cycle. The requester must re-present after reset.
- **Stall.** `alu_ready_i` = 0 blocks all grants. Slots can still be popped.

## Structure
- **Shared package.** `ALU_OP_WIDTH`, `ALU_ADD` and the `VEC_MODE*` encodings come from the shared `riscv_defines` package; no local redefinition.
- **Sub-module `riscv_rr_arbiter`.** Parameterised width; inputs are the eligible vector and `rr_ptr`; outputs are the one-hot grant and the encoded index. It is reusable for the LSU and the shared DSP port.
- **Top.** Holds the payload mux, response slots, pointer register and counter.
- **Size.** Roughly 200 lines.

## Test plan
- **Single requester.** `NUM_REQ`=2. Requester 0 issues `ALU_ADD` with a=5, b=7 → `req_ready_o`=01 in the same cycle; next cycle `rsp_valid_o`=01 with `rsp_result_o[0]`=12.
- **Round-robin fairness.** Both requesters valid continuously with `rsp_ready_i`=11 → grants alternate 01,10,01,10 starting from 01 after reset, and `contention_cnt_o` increments by 1 per cycle.
- **Slot backpressure.** Requester 1's slot is full and `rsp_ready_i[1]`=0 → requester 1 is never granted and requester 0 receives every grant. Raising `rsp_ready_i[1]` → requester 1 is granted in that same cycle.
- **Comparison op.** `ALU_SLTS` with a=0xFFFFFFFF, b=1 → `rsp_cmp_o`=1 and `rsp_result_o`=1. `ALU_SLTU` with the same operands → both 0.
- **Counter saturation and clear.** `CNT_WIDTH`=4 with 20 contention cycles → the counter holds 15. `cnt_clear_i` asserted in a contention cycle → next value is 0.
- **Reset mid-operation.** `rst` pulsed one cycle with `rsp_valid_o`=11 → the next cycle shows `rsp_valid_o`=00, `rr_ptr`=0, and the first subsequent grant goes to requester 0.

Source files
------------

// File: rtl/riscv_alu_arbiter_pkg.sv
// Arbiter-local helpers shared by the ALU arbiter top and its round-robin core.
package riscv_alu_arbiter_pkg;

  localparam int MAX_REQ = 8;

  // Pointer position just after requester k, wrapping at n requesters.
  function automatic int rr_next(input int k, input int n);
    int nxt;
    nxt = k + 1;
    if (nxt >= n) begin
      nxt = 0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/riscv_defines.sv
// Shared core encodings: ALU operator codes and vector-mode values used by the EX stage,
// the basic ALU and every block that drives it.
package riscv_defines;

  localparam int ALU_OP_WIDTH = 7;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 7'b0011000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 7'b0011001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 7'b0101111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 7'b0101110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 7'b0010101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 7'b0100100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 7'b0100101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 7'b0100111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS = 7'b0000010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 7'b0000011;

  localparam logic [1:0] VEC_MODE32 = 2'b00;
  localparam logic [1:0] VEC_MODE16 = 2'b10;
  localparam logic [1:0] VEC_MODE8  = 2'b11;

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after ptr_i, wrapping.
// Reused by the ALU, LSU and shared DSP port arbiters.
module riscv_rr_arbiter
  import riscv_alu_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grant_idx_o,
  output logic          grant_valid_o
);

  logic [PW-1:0] idx_s;

  // Search forward from the pointer; the first hit wins and later hits are masked.
  always_comb begin
    grant_o       = {N{1'b0}};
    grant_idx_o   = {PW{1'b0}};
    grant_valid_o = 1'b0;
    idx_s         = {PW{1'b0}};
    for (int off = 0; off < N; off++) begin
      idx_s = PW'((int'(ptr_i) + off) % N);
      if (!grant_valid_o && eligible_i[idx_s]) begin
        grant_o[idx_s] = 1'b1;
        grant_idx_o    = idx_s;
        grant_valid_o  = 1'b1;
      end else begin
        grant_valid_o = grant_valid_o;
      end
    end
  end

endmodule

// File: rtl/riscv_alu_arbiter.sv
// Shares one single-cycle basic ALU between NUM_REQ requesters with round-robin grants,
// one-deep registered response slots and a saturating contention counter.
module riscv_alu_arbiter
  import riscv_defines::*;
  import riscv_alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ-1:0]                        req_valid_i,
  output logic [NUM_REQ-1:0]                        req_ready_o,
  input  logic [NUM_REQ-1:0][ALU_OP_WIDTH-1:0]      req_operator_i,
  input  logic [NUM_REQ-1:0][31:0]                  req_operand_a_i,
  input  logic [NUM_REQ-1:0][31:0]                  req_operand_b_i,
  input  logic [NUM_REQ-1:0][1:0]                   req_vector_mode_i,
  output logic [NUM_REQ-1:0]                        rsp_valid_o,
  input  logic [NUM_REQ-1:0]                        rsp_ready_i,
  output logic [NUM_REQ-1:0][31:0]                  rsp_result_o,
  output logic [NUM_REQ-1:0]                        rsp_cmp_o,
  output logic [ALU_OP_WIDTH-1:0]                   alu_operator_o,
  output logic [31:0]                               alu_operand_a_o,
  output logic [31:0]                               alu_operand_b_o,
  output logic [1:0]                                alu_vector_mode_o,
  output logic                                      alu_ex_ready_o,
  input  logic [31:0]                               alu_result_i,
  input  logic                                      alu_cmp_i,
  input  logic                                      alu_ready_i,
  input  logic                                      cnt_clear_i,
  output logic [CNT_WIDTH-1:0]                      contention_cnt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]              rr_ptr_r;
  logic [NUM_REQ-1:0]            eligible_s;
  logic [NUM_REQ-1:0]            grant_s;
  logic [PTR_W-1:0]              grant_idx_s;
  logic                          grant_any_s;
  logic [NUM_REQ-1:0]            rsp_valid_r;
  logic [NUM_REQ-1:0]            rsp_cmp_r;
  logic [NUM_REQ-1:0][31:0]      rsp_result_r;
  logic [CNT_WIDTH-1:0]          cnt_r;
  logic                          contention_s;
  logic [ALU_OP_WIDTH-1:0]       op_or_s;
  logic [31:0]                   a_or_s;
  logic [31:0]                   b_or_s;
  logic [1:0]                    vm_or_s;

  // A slot being popped this cycle can take a new result, which keeps full throughput.
  always_comb begin
    eligible_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_s[i] = req_valid_i[i] & alu_ready_i & ~rst & (~rsp_valid_r[i] | rsp_ready_i[i]);
    end
  end

  riscv_rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_rr_arbiter (
    .eligible_i    (eligible_s),
    .ptr_i         (rr_ptr_r),
    .grant_o       (grant_s),
    .grant_idx_o   (grant_idx_s),
    .grant_valid_o (grant_any_s)
  );

  assign req_ready_o    = grant_s;
  assign alu_ex_ready_o = 1'b1;

  // One-hot AND-OR payload mux; an idle ALU sees ADD with zero operands to limit toggling.
  always_comb begin
    op_or_s = {ALU_OP_WIDTH{1'b0}};
    a_or_s  = 32'h0000_0000;
    b_or_s  = 32'h0000_0000;
    vm_or_s = 2'b00;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_or_s = op_or_s | ({ALU_OP_WIDTH{grant_s[i]}} & req_operator_i[i]);
      a_or_s  = a_or_s  | ({32{grant_s[i]}} & req_operand_a_i[i]);
      b_or_s  = b_or_s  | ({32{grant_s[i]}} & req_operand_b_i[i]);
      vm_or_s = vm_or_s | ({2{grant_s[i]}} & req_vector_mode_i[i]);
    end
    if (grant_any_s) begin
      alu_operator_o    = op_or_s;
      alu_operand_a_o   = a_or_s;
      alu_operand_b_o   = b_or_s;
      alu_vector_mode_o = vm_or_s;
    end else begin
      alu_operator_o    = ALU_ADD;
      alu_operand_a_o   = 32'h0000_0000;
      alu_operand_b_o   = 32'h0000_0000;
      alu_vector_mode_o = VEC_MODE32;
    end
  end

  // Round-robin pointer moves past the winner and holds when nobody is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= {PTR_W{1'b0}};
    end else if (grant_any_s) begin
      rr_ptr_r <= PTR_W'(rr_next(int'(grant_idx_s), NUM_REQ));
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Response slots: a grant overwrites, a pop of a full slot empties it, data otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r  <= {NUM_REQ{1'b0}};
      rsp_cmp_r    <= {NUM_REQ{1'b0}};
      rsp_result_r <= {NUM_REQ{32'h0000_0000}};
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_s[i]) begin
          rsp_valid_r[i]  <= 1'b1;
          rsp_cmp_r[i]    <= alu_cmp_i;
          rsp_result_r[i] <= alu_result_i;
        end else if (rsp_valid_r[i] && rsp_ready_i[i]) begin
          rsp_valid_r[i] <= 1'b0;
        end else begin
          rsp_valid_r[i] <= rsp_valid_r[i];
        end
      end
    end
  end

  assign contention_s = |(req_valid_i & ~grant_s);

  // Saturating contention counter; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (cnt_clear_i) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (contention_s && (cnt_r != {CNT_WIDTH{1'b1}})) begin
      cnt_r <= cnt_r + CNT_WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign rsp_valid_o      = rsp_valid_r;
  assign rsp_cmp_o        = rsp_cmp_r;
  assign rsp_result_o     = rsp_result_r;
  assign contention_cnt_o = cnt_r;

endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// Bench for riscv_alu_arbiter: directed scenarios plus constrained-random traffic checked
// against a behavioural round-robin/slot/counter model and a behavioural ALU stand-in.
module tb_riscv_alu_arbiter;
  import riscv_defines::*;

  localparam int NR   = 2;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic                            clk;
  logic                            rst;
  logic [NR-1:0]                   req_valid;
  logic [NR-1:0]                   req_ready_o;
  logic [NR-1:0][ALU_OP_WIDTH-1:0] req_op;
  logic [NR-1:0][31:0]             req_a;
  logic [NR-1:0][31:0]             req_b;
  logic [NR-1:0][1:0]              req_vm;
  logic [NR-1:0]                   rsp_valid_o;
  logic [NR-1:0]                   rsp_ready;
  logic [NR-1:0][31:0]             rsp_result_o;
  logic [NR-1:0]                   rsp_cmp_o;
  logic [ALU_OP_WIDTH-1:0]         alu_operator_o;
  logic [31:0]                     alu_operand_a_o;
  logic [31:0]                     alu_operand_b_o;
  logic [1:0]                      alu_vector_mode_o;
  logic                            alu_ex_ready_o;
  logic [31:0]                     alu_result;
  logic                            alu_cmp;
  logic                            alu_ready;
  logic                            cnt_clear;
  logic [CW-1:0]                   contention_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  int             m_ptr;
  logic [NR-1:0]  m_valid;
  logic [31:0]    m_res [NR];
  logic           m_cmp [NR];
  int             m_cnt;
  logic [NR-1:0]  last_ready;
  logic [NR-1:0]  exp_ready;

  logic [ALU_OP_WIDTH-1:0] op_tab [10];

  riscv_alu_arbiter #(
    .NUM_REQ   (NR),
    .CNT_WIDTH (CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready_o),
    .req_operator_i    (req_op),
    .req_operand_a_i   (req_a),
    .req_operand_b_i   (req_b),
    .req_vector_mode_i (req_vm),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready),
    .rsp_result_o      (rsp_result_o),
    .rsp_cmp_o         (rsp_cmp_o),
    .alu_operator_o    (alu_operator_o),
    .alu_operand_a_o   (alu_operand_a_o),
    .alu_operand_b_o   (alu_operand_b_o),
    .alu_vector_mode_o (alu_vector_mode_o),
    .alu_ex_ready_o    (alu_ex_ready_o),
    .alu_result_i      (alu_result),
    .alu_cmp_i         (alu_cmp),
    .alu_ready_i       (alu_ready),
    .cnt_clear_i       (cnt_clear),
    .contention_cnt_o  (contention_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: {comparison, result}.
  function automatic logic [32:0] alu_ref(input logic [ALU_OP_WIDTH-1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        c;
    c = 1'b0;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_XOR:  r = a ^ b;
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_SLTS: begin c = ($signed(a) < $signed(b)); r = {31'd0, c}; end
      ALU_SLTU: begin c = (a < b); r = {31'd0, c}; end
      default:  r = 32'd0;
    endcase
    return {c, r};
  endfunction

  logic [32:0] alu_out;
  always_comb begin
    alu_out    = alu_ref(alu_operator_o, alu_operand_a_o, alu_operand_b_o);
    alu_result = alu_out[31:0];
    alu_cmp    = alu_out[32];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Winner under the rules: search from the pointer for valid && slot free-or-popping.
  function automatic int model_grant();
    int idx;
    if (rst || !alu_ready) return -1;
    for (int off = 0; off < NR; off++) begin
      idx = (m_ptr + off) % NR;
      if (req_valid[idx] && (!m_valid[idx] || rsp_ready[idx])) return idx;
    end
    return -1;
  endfunction

  task automatic tick();
    int          g;
    logic [NR-1:0] er;
    logic        cont;
    logic [32:0] r;
    @(negedge clk);
    g  = model_grant();
    er = '0;
    if (g >= 0) er = NR'(1) << g;
    exp_ready  = er;
    last_ready = req_ready_o;
    check("req_ready", req_ready_o, er);
    check("ex_ready", alu_ex_ready_o, 1);
    if (g >= 0) begin
      check("alu_op", alu_operator_o, req_op[g]);
      check("alu_a", alu_operand_a_o, req_a[g]);
      check("alu_b", alu_operand_b_o, req_b[g]);
      check("alu_vm", alu_vector_mode_o, req_vm[g]);
    end else begin
      check("idle_op", alu_operator_o, ALU_ADD);
      check("idle_ops", {alu_operand_a_o, alu_operand_b_o[29:0], alu_vector_mode_o}, 0);
    end
    cont = |(req_valid & ~er);
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_valid = '0; m_cnt = 0;
      for (int i = 0; i < NR; i++) begin m_res[i] = 32'd0; m_cmp[i] = 1'b0; end
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (i == g) begin
          r = alu_ref(req_op[i], req_a[i], req_b[i]);
          m_res[i] = r[31:0]; m_cmp[i] = r[32]; m_valid[i] = 1'b1;
        end else if (m_valid[i] && rsp_ready[i]) begin
          m_valid[i] = 1'b0;
        end
      end
      if (g >= 0) m_ptr = (g + 1) % NR;
      if (cnt_clear) m_cnt = 0;
      else if (cont && m_cnt < CMAX) m_cnt++;
    end
    #1;
    check("rsp_valid", rsp_valid_o, m_valid);
    for (int i = 0; i < NR; i++) begin
      check("rsp_result", rsp_result_o[i], m_res[i]);
      check("rsp_cmp", rsp_cmp_o[i], m_cmp[i]);
    end
    check("cnt", contention_cnt_o, m_cnt);
  endtask

  task automatic new_payload(input int i);
    req_op[i] = op_tab[$urandom_range(0, 9)];
    req_a[i]  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    req_b[i]  = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
    req_vm[i] = 2'($urandom_range(0, 3));
  endtask

  initial begin
    op_tab = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
               ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLTS, ALU_SLTU};
    rst = 1'b1; req_valid = '0; rsp_ready = '0; alu_ready = 1'b1; cnt_clear = 1'b0;
    for (int i = 0; i < NR; i++) begin
      req_op[i] = ALU_ADD; req_a[i] = 32'd0; req_b[i] = 32'd0; req_vm[i] = VEC_MODE32;
    end
    m_ptr = 0; m_valid = '0; m_cnt = 0;
    for (int i = 0; i < NR; i++) begin m_res[i] = 32'd0; m_cmp[i] = 1'b0; end
    tick(); tick();
    check("rst_valid", rsp_valid_o, 0);
    check("rst_cnt", contention_cnt_o, 0);
    rst = 1'b0;

    // Single requester ADD 5+7.
    req_valid = 2'b01; req_op[0] = ALU_ADD; req_a[0] = 32'd5; req_b[0] = 32'd7;
    tick();
    check("single_ready", last_ready, 2'b01);
    check("single_valid", rsp_valid_o, 2'b01);
    check("single_res", rsp_result_o[0], 32'd12);
    req_valid = 2'b00; rsp_ready = 2'b11;
    tick();

    // Signed vs unsigned compare.
    req_valid = 2'b01; req_op[0] = ALU_SLTS; req_a[0] = 32'hFFFF_FFFF; req_b[0] = 32'd1;
    tick();
    check("slts_cmp", rsp_cmp_o[0], 1);
    check("slts_res", rsp_result_o[0], 32'd1);
    req_op[0] = ALU_SLTU;
    tick();
    check("sltu_cmp", rsp_cmp_o[0], 0);
    check("sltu_res", rsp_result_o[0], 32'd0);

    // ALU stall blocks every grant.
    alu_ready = 1'b0; req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_ready", last_ready, 2'b00);
    end
    alu_ready = 1'b1;

    // Slot backpressure on requester 1.
    req_valid = 2'b00; rsp_ready = 2'b11; tick();
    req_valid = 2'b10; rsp_ready = 2'b00; tick();
    check("bp_fill", rsp_valid_o, 2'b10);
    req_valid = 2'b11; rsp_ready = 2'b01;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("bp_only0", last_ready, 2'b01);
    end
    rsp_ready = 2'b11; tick();
    check("bp_release", last_ready, 2'b10);

    // Fairness from reset, then counter saturation and clear.
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_grant", last_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_cnt", contention_cnt_o, k + 1);
    end
    for (int k = 0; k < 20; k++) tick();
    check("cnt_sat", contention_cnt_o, 15);
    cnt_clear = 1'b1; tick();
    check("cnt_clear", contention_cnt_o, 0);
    cnt_clear = 1'b0;

    // Reset with both slots full.
    req_valid = 2'b00; rsp_ready = 2'b11; tick();
    req_valid = 2'b11; rsp_ready = 2'b00; tick(); tick();
    check("midrst_full", rsp_valid_o, 2'b11);
    rst = 1'b1; tick();
    check("midrst_ready", last_ready, 2'b00);
    check("midrst_valid", rsp_valid_o, 2'b00);
    rst = 1'b0; tick();
    check("midrst_first", last_ready, 2'b01);

    // Random traffic; non-granted requests hold valid and payload.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!(req_valid[i] && !exp_ready[i])) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          new_payload(i);
        end
      end
      rsp_ready = NR'($urandom_range(0, 3));
      alu_ready = ($urandom_range(0, 9) != 0);
      cnt_clear = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
